// File: rtl/fetch_buffer.sv
// Circular fetch-packet queue between IF and the FIFO->ID register.
// Head outputs read the oldest entry; an empty queue presents a NOP bubble.
module fetch_buffer #(
    parameter int          DEPTH    = 8,
    parameter int          PW       = 235,
    parameter logic [31:0] INST_NOP = 32'h0340_0000,
    parameter logic [31:0] PC_RESET = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        if_readygo,
    output logic        buf_allowin,
    input  logic [31:0] if_inst0,
    input  logic [31:0] if_inst1,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_pcAdd,
    input  logic [31:0] if_pc_next,
    input  logic [31:0] if_badv,
    input  logic [31:0] if_cookie_out,
    input  logic [6:0]  if_exception,
    input  logic [1:0]  if_excp_flag,
    input  logic [1:0]  if_priv_flag,
    input  logic        fifo_allowin,
    output logic        fifo_readygo,
    output logic [31:0] fifo_inst0,
    output logic [31:0] fifo_inst1,
    output logic [31:0] fifo_pc,
    output logic [31:0] fifo_pcAdd,
    output logic [31:0] fifo_pc_next,
    output logic [31:0] fifo_badv,
    output logic [31:0] fifo_cookie_out,
    output logic [6:0]  fifo_exception,
    output logic [1:0]  fifo_excp_flag,
    output logic [1:0]  fifo_priv_flag,
    output logic        fetch_buf_empty,
    output logic        fetch_buf_full
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [PW-1:0] BUBBLE = {INST_NOP, INST_NOP, PC_RESET,
                                        PC_RESET + 32'd4, PC_RESET + 32'd8,
                                        PC_RESET, 32'd1958, 7'd0, 2'd0, 2'd0};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [PW-1:0] mem_q [DEPTH];

    logic          push_s;
    logic          pop_s;
    logic          empty_s;
    logic          full_s;
    logic          clear_s;
    logic [PW-1:0] in_pkt_s;
    logic [PW-1:0] head_s;

    // Status is taken from the registered count only, so allowin never sees fifo_allowin.
    assign empty_s  = (count_q == {(AW+1){1'b0}});
    assign full_s   = (count_q == (AW+1)'(DEPTH));
    assign clear_s  = !rstn || flush;
    assign push_s   = if_readygo && !full_s;
    assign pop_s    = fifo_allowin && !empty_s;

    assign in_pkt_s = {if_inst0, if_inst1, if_pc, if_pcAdd, if_pc_next, if_badv,
                       if_cookie_out, if_exception, if_excp_flag, if_priv_flag};

    // Next-state for pointers and occupancy; clear discards any same-cycle push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_s) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Packet RAM write.
    always_ff @(posedge clk) begin
        if (push_s && !clear_s) begin
            mem_q[wr_ptr_q] <= in_pkt_s;
        end
    end

    // Head packet selection.
    always_comb begin
        head_s = BUBBLE;
        if (empty_s) begin
            head_s = BUBBLE;
        end else begin
            head_s = mem_q[rd_ptr_q];
        end
    end

    assign {fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next, fifo_badv,
            fifo_cookie_out, fifo_exception, fifo_excp_flag, fifo_priv_flag} = head_s;

    assign fifo_readygo    = !empty_s;
    assign buf_allowin     = !full_s;
    assign fetch_buf_empty = empty_s;
    assign fetch_buf_full  = full_s;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_buffer;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] INST_NOP = 32'h0340_0000;
    localparam logic [31:0] PC_RESET = 32'h1C00_0000;
    localparam logic [234:0] BUBBLE  = {INST_NOP, INST_NOP, PC_RESET, PC_RESET + 32'd4,
                                        PC_RESET + 32'd8, PC_RESET, 32'd1958, 7'd0, 2'd0, 2'd0};

    logic clk = 1'b0;
    logic rstn, flush, if_readygo, fifo_allowin;
    logic [31:0] if_inst0, if_inst1, if_pc, if_pcAdd, if_pc_next, if_badv, if_cookie_out;
    logic [6:0]  if_exception;
    logic [1:0]  if_excp_flag, if_priv_flag;
    logic buf_allowin, fifo_readygo, fetch_buf_empty, fetch_buf_full;
    logic [31:0] fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next, fifo_badv, fifo_cookie_out;
    logic [6:0]  fifo_exception;
    logic [1:0]  fifo_excp_flag, fifo_priv_flag;
    logic [234:0] act_pkt;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_buffer #(.DEPTH(DEPTH), .PW(235), .INST_NOP(INST_NOP), .PC_RESET(PC_RESET)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .if_readygo(if_readygo), .buf_allowin(buf_allowin),
        .if_inst0(if_inst0), .if_inst1(if_inst1), .if_pc(if_pc), .if_pcAdd(if_pcAdd),
        .if_pc_next(if_pc_next), .if_badv(if_badv), .if_cookie_out(if_cookie_out),
        .if_exception(if_exception), .if_excp_flag(if_excp_flag), .if_priv_flag(if_priv_flag),
        .fifo_allowin(fifo_allowin), .fifo_readygo(fifo_readygo),
        .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1), .fifo_pc(fifo_pc), .fifo_pcAdd(fifo_pcAdd),
        .fifo_pc_next(fifo_pc_next), .fifo_badv(fifo_badv), .fifo_cookie_out(fifo_cookie_out),
        .fifo_exception(fifo_exception), .fifo_excp_flag(fifo_excp_flag), .fifo_priv_flag(fifo_priv_flag),
        .fetch_buf_empty(fetch_buf_empty), .fetch_buf_full(fetch_buf_full)
    );

    assign act_pkt = {fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next, fifo_badv,
                      fifo_cookie_out, fifo_exception, fifo_excp_flag, fifo_priv_flag};

    always #5 clk = ~clk;

    // Every packet field is derived from its pc so the whole head packet can be predicted.
    function automatic logic [234:0] pkt_of(input logic [31:0] pc);
        return {pc ^ 32'hA5A5_0000, ~pc, pc, pc + 32'd4, pc + 32'd8, pc ^ 32'h0000_FFFF,
                {16'h0, pc[15:0]}, pc[8:2], pc[3:2], pc[5:4]};
    endfunction

    task automatic drive(input logic r, input logic f, input logic rdy, input logic alw,
                         input logic [31:0] pc);
        rstn = r; flush = f; if_readygo = rdy; fifo_allowin = alw;
        {if_inst0, if_inst1, if_pc, if_pcAdd, if_pc_next, if_badv, if_cookie_out,
         if_exception, if_excp_flag, if_priv_flag} = pkt_of(pc);
    endtask

    task automatic step(input logic r, input logic f, input logic rdy, input logic alw,
                        input logic [31:0] pc);
        drive(r, f, rdy, alw, pc);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic e_empty, input logic e_full,
                         input logic [31:0] e_pc);
        logic [234:0] exp_pkt;
        exp_pkt = e_empty ? BUBBLE : pkt_of(e_pc);
        n_cmp++;
        if (fetch_buf_empty !== e_empty || fetch_buf_full !== e_full ||
            fifo_readygo !== !e_empty || buf_allowin !== !e_full || act_pkt !== exp_pkt) begin
            n_fail++;
            $display("FAIL %s: got empty=%b full=%b readygo=%b allowin=%b pc=%h pkt=%h ; want empty=%b full=%b pkt=%h",
                     name, fetch_buf_empty, fetch_buf_full, fifo_readygo, buf_allowin, fifo_pc,
                     act_pkt, e_empty, e_full, exp_pkt);
        end
    endtask

    typedef struct {
        logic        rstn;
        logic        flush;
        logic        rdy;
        logic        alw;
        logic [31:0] pc;
        logic        exp_empty;
        logic        exp_full;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[$];
    logic [31:0] model_q[$];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        // Expected state is checked first, then the row's inputs are applied for one cycle.
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0000, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0004, 1'b0, 1'b0, 32'h1C00_0000});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0008, 1'b0, 1'b0, 32'h1C00_0000});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h1C00_0000});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h1C00_0004});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h1C00_0008});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_000C, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0010, 1'b0, 1'b0, 32'h1C00_000C});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0014, 1'b0, 1'b0, 32'h1C00_000C});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0018, 1'b0, 1'b0, 32'h1C00_000C});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_001C, 1'b0, 1'b0, 32'h1C00_000C});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 32'h1C00_0020, 1'b0, 1'b0, 32'h1C00_000C});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0024, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h1C00_0024});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0028, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_002C, 1'b0, 1'b0, 32'h1C00_0028});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0030, 1'b0, 1'b0, 32'h1C00_0028});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0034, 1'b0, 1'b0, 32'h1C00_0028});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'h1C00_0038, 1'b0, 1'b0, 32'h1C00_0028});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 32'h1C00_003C, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 32'h1C00_0040, 1'b0, 1'b0, 32'h1C00_003C});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h1C00_0040});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0});

        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("vec%0d", i), tbl[i].exp_empty, tbl[i].exp_full, tbl[i].exp_pc);
            step(tbl[i].rstn, tbl[i].flush, tbl[i].rdy, tbl[i].alw, tbl[i].pc);
        end

        // Fill to full, refuse a 9th packet, then refuse a push even with a same-cycle pop.
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("fill%0d", i), i == 0, 1'b0, 32'h1C00_1000);
            step(1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_1000 + 32'(4 * i));
        end
        check("full_after_8", 1'b0, 1'b1, 32'h1C00_1000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEE0);
        check("ninth_ignored", 1'b0, 1'b1, 32'h1C00_1000);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEE4);
        check("pop_while_full", 1'b0, 1'b0, 32'h1C00_1004);
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("drain%0d", i), 1'b0, 1'b0, 32'h1C00_1000 + 32'(4 * i));
            step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        end
        check("drained_empty", 1'b1, 1'b0, 32'h0);

        // Streaming push+pop every cycle; pointers wrap twice.
        for (int i = 0; i < 20; i++) begin
            check($sformatf("stream%0d", i), i == 0, 1'b0, 32'h1C00_2000 + 32'(4 * (i - 1)));
            step(1'b1, 1'b0, 1'b1, 1'b1, 32'h1C00_2000 + 32'(4 * i));
        end
        check("stream_last", 1'b0, 1'b0, 32'h1C00_2000 + 32'(4 * 19));
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        check("stream_empty", 1'b1, 1'b0, 32'h0);

        // Randomized traffic against an ordered-queue model.
        for (int c = 0; c < 3000; c++) begin
            logic r, f, rdy, alw;
            logic [31:0] pc;
            int phase;
            phase = (c / 200) % 3;
            r   = ($urandom_range(0, 99) >= 2);
            f   = ($urandom_range(0, 99) < 3);
            rdy = ($urandom_range(0, 99) < (phase == 0 ? 85 : (phase == 1 ? 50 : 20)));
            alw = ($urandom_range(0, 99) < (phase == 0 ? 20 : (phase == 1 ? 50 : 85)));
            pc  = {$urandom} & 32'hFFFF_FFFC;
            check($sformatf("rand%0d", c), model_q.size() == 0, model_q.size() == DEPTH,
                  (model_q.size() == 0) ? 32'h0 : model_q[0]);
            if (!r || f) begin
                model_q.delete();
            end else begin
                logic can_push;
                can_push = rdy && (model_q.size() < DEPTH);
                if (alw && model_q.size() > 0) void'(model_q.pop_front());
                if (can_push) model_q.push_back(pc);
            end
            step(r, f, rdy, alw, pc);
        end
        check("rand_final", model_q.size() == 0, model_q.size() == DEPTH,
              (model_q.size() == 0) ? 32'h0 : model_q[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
